// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel-clock divider and 640x480@60 raster timing generator
// All outputs are registered from the next-state counter values, so they move on the same edge as the counters.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       n25MHZCLK,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       n_sync,
  output logic       n_blanc,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [9:0]    H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_MAX    = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync ending exactly at 1024 does not wrap to zero
  localparam logic [10:0]   H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0]   V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0]   HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be even and >= 2");
  end

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          tick_q, tick_d;
  logic          fs_q, fs_d;
  logic          pclk_q, pclk_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          nb_q, nb_d;

  always_comb begin
    div_d  = div_q;
    h_d    = h_q;
    v_d    = v_q;
    tick_d = 1'b0;
    fs_d   = 1'b0;
    if (div_q == DIV_MAX) begin
      div_d  = '0;
      tick_d = 1'b1;
      if (h_q == H_MAX) begin
        h_d = '0;
        if (v_q == V_MAX) begin
          v_d  = '0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
    pclk_d = (div_d >= DIV_HALF);
    hs_d   = !(({1'b0, h_d} >= HS_START) && ({1'b0, h_d} < HS_END));
    vs_d   = !(({1'b0, v_d} >= VS_START) && ({1'b0, v_d} < VS_END));
    nb_d   = ({1'b0, h_d} < H_VIS) && ({1'b0, v_d} < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      tick_q <= 1'b0;
      fs_q   <= 1'b0;
      pclk_q <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      nb_q   <= 1'b1;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      tick_q <= tick_d;
      fs_q   <= fs_d;
      pclk_q <= pclk_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      nb_q   <= nb_d;
    end
  end

  assign n25MHZCLK   = pclk_q;
  assign pixel_tick  = tick_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign n_sync      = 1'b0;
  assign n_blanc     = nb_q;
  assign x           = h_q;
  assign y           = v_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
// Three instances: default timing, CLK_DIV=4, and a shrunken raster for whole-frame behaviour.
module tb_vga_timing_gen;

  typedef logic [26:0] ovec_t;  // {tick, fs, pclk, hs, vs, nb, nsync, x, y}

  typedef struct {
    int         t;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       nb;
    logic       tick;
  } vec_t;

  logic clk;
  logic rst_def, rst_d4, rst_sm;
  int   t_def, t_d4, t_sm;
  int   checks, errors;
  logic prev_tick, prev_fs;

  logic       pclk_def, tick_def, hs_def, vs_def, ns_def, nb_def, fs_def;
  logic [9:0] x_def, y_def;
  logic       pclk_d4, tick_d4, hs_d4, vs_d4, ns_d4, nb_d4, fs_d4;
  logic [9:0] x_d4, y_d4;
  logic       pclk_sm, tick_sm, hs_sm, vs_sm, ns_sm, nb_sm, fs_sm;
  logic [9:0] x_sm, y_sm;

  ovec_t ov_def, ov_d4, ov_sm;
  assign ov_def = {tick_def, fs_def, pclk_def, hs_def, vs_def, nb_def, ns_def, x_def, y_def};
  assign ov_d4  = {tick_d4, fs_d4, pclk_d4, hs_d4, vs_d4, nb_d4, ns_d4, x_d4, y_d4};
  assign ov_sm  = {tick_sm, fs_sm, pclk_sm, hs_sm, vs_sm, nb_sm, ns_sm, x_sm, y_sm};

  vga_timing_gen u_def (
    .clk(clk), .reset(rst_def), .n25MHZCLK(pclk_def), .pixel_tick(tick_def),
    .hsync(hs_def), .vsync(vs_def), .n_sync(ns_def), .n_blanc(nb_def),
    .x(x_def), .y(y_def), .frame_start(fs_def)
  );

  vga_timing_gen #(.CLK_DIV(4)) u_d4 (
    .clk(clk), .reset(rst_d4), .n25MHZCLK(pclk_d4), .pixel_tick(tick_d4),
    .hsync(hs_d4), .vsync(vs_d4), .n_sync(ns_d4), .n_blanc(nb_d4),
    .x(x_d4), .y(y_d4), .frame_start(fs_d4)
  );

  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_sm (
    .clk(clk), .reset(rst_sm), .n25MHZCLK(pclk_sm), .pixel_tick(tick_sm),
    .hsync(hs_sm), .vsync(vs_sm), .n_sync(ns_sm), .n_blanc(nb_sm),
    .x(x_sm), .y(y_sm), .frame_start(fs_sm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs as a pure function of clocks elapsed since reset release.
  function automatic ovec_t model(input int t, input int d, input int ha, input int hf,
                                  input int hsw, input int hb, input int va, input int vf,
                                  input int vsw, input int vb);
    int    ht, vt, n, hx, vy;
    logic  tick, fs, pclk, hs, vs, nb;
    ht   = ha + hf + hsw + hb;
    vt   = va + vf + vsw + vb;
    n    = t / d;
    hx   = n % ht;
    vy   = (n / ht) % vt;
    tick = (t > 0) && (t % d == 0);
    fs   = tick && (n % (ht * vt) == 0);
    pclk = (t % d) >= (d / 2);
    hs   = !(hx >= ha + hf && hx < ha + hf + hsw);
    vs   = !(vy >= va + vf && vy < va + vf + vsw);
    nb   = (hx < ha) && (vy < va);
    return {tick, fs, pclk, hs, vs, nb, 1'b0, 10'(hx), 10'(vy)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t_def = rst_def ? 0 : t_def + 1;
    t_d4  = rst_d4  ? 0 : t_d4 + 1;
    t_sm  = rst_sm  ? 0 : t_sm + 1;
    check("model_def", 32'(ov_def), 32'(model(t_def, 2, 640, 16, 96, 48, 480, 10, 2, 33)));
    check("model_d4",  32'(ov_d4),  32'(model(t_d4, 4, 640, 16, 96, 48, 480, 10, 2, 33)));
    check("model_sm",  32'(ov_sm),  32'(model(t_sm, 2, 8, 2, 3, 3, 6, 2, 2, 2)));
    check("tick_pair", 32'(prev_tick && tick_def), 32'd0);
    check("fs_pair",   32'(prev_fs && fs_sm), 32'd0);
    prev_tick = tick_def;
    prev_fs   = fs_sm;
  endtask

  localparam ovec_t RST_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0};

  vec_t tbl[11];
  int   k, vs_low;

  initial begin
    checks = 0; errors = 0;
    t_def = 0; t_d4 = 0; t_sm = 0;
    prev_tick = 1'b0; prev_fs = 1'b0;
    rst_def = 1'b1; rst_d4 = 1'b1; rst_sm = 1'b1;

    tbl[0]  = '{t: 0,    x: 10'd0,   y: 10'd0, hs: 1'b1, nb: 1'b1, tick: 1'b0};
    tbl[1]  = '{t: 1,    x: 10'd0,   y: 10'd0, hs: 1'b1, nb: 1'b1, tick: 1'b0};
    tbl[2]  = '{t: 2,    x: 10'd1,   y: 10'd0, hs: 1'b1, nb: 1'b1, tick: 1'b1};
    tbl[3]  = '{t: 1279, x: 10'd639, y: 10'd0, hs: 1'b1, nb: 1'b1, tick: 1'b0};
    tbl[4]  = '{t: 1280, x: 10'd640, y: 10'd0, hs: 1'b1, nb: 1'b0, tick: 1'b1};
    tbl[5]  = '{t: 1311, x: 10'd655, y: 10'd0, hs: 1'b1, nb: 1'b0, tick: 1'b0};
    tbl[6]  = '{t: 1312, x: 10'd656, y: 10'd0, hs: 1'b0, nb: 1'b0, tick: 1'b1};
    tbl[7]  = '{t: 1503, x: 10'd751, y: 10'd0, hs: 1'b0, nb: 1'b0, tick: 1'b0};
    tbl[8]  = '{t: 1504, x: 10'd752, y: 10'd0, hs: 1'b1, nb: 1'b0, tick: 1'b1};
    tbl[9]  = '{t: 1599, x: 10'd799, y: 10'd0, hs: 1'b1, nb: 1'b0, tick: 1'b0};
    tbl[10] = '{t: 1600, x: 10'd0,   y: 10'd1, hs: 1'b1, nb: 1'b1, tick: 1'b1};

    repeat (3) step();
    check("rst_def", 32'(ov_def), 32'(RST_VEC));
    check("rst_d4",  32'(ov_d4),  32'(RST_VEC));
    check("rst_sm",  32'(ov_sm),  32'(RST_VEC));

    // One full line of the default raster against the hand table
    rst_def = 1'b0;
    for (int i = 0; i < 11; i++) begin
      while (t_def < tbl[i].t) step();
      check("tbl_x",    32'(x_def),    32'(tbl[i].x));
      check("tbl_y",    32'(y_def),    32'(tbl[i].y));
      check("tbl_hs",   32'(hs_def),   32'(tbl[i].hs));
      check("tbl_nb",   32'(nb_def),   32'(tbl[i].nb));
      check("tbl_tick", 32'(tick_def), 32'(tbl[i].tick));
    end

    // CLK_DIV=4: line is 3200 clks
    rst_d4 = 1'b0;
    k = 0;
    while (t_d4 < 3199 && k < 4000) begin step(); k++; end
    check("d4_x_end", 32'(x_d4), 32'd799);
    check("d4_y_end", 32'(y_d4), 32'd0);
    step();
    check("d4_x_wrap", 32'(x_d4), 32'd0);
    check("d4_y_wrap", 32'(y_d4), 32'd1);
    check("d4_tick",   32'(tick_d4), 32'd1);

    // Small raster: one frame = 16*12*2 = 384 clks, vsync low 2 lines = 64 clks
    rst_sm = 1'b1;
    step(); step();
    rst_sm = 1'b0;
    k = 0;
    while (!fs_sm && k < 1000) begin step(); k++; end
    check("fs1_time", 32'(t_sm), 32'd384);
    vs_low = 0;
    step();
    k = 0;
    while (!fs_sm && k < 1000) begin
      if (!vs_sm) vs_low++;
      step(); k++;
    end
    check("fs2_time", 32'(t_sm), 32'd768);
    check("vs_low_clks", 32'(vs_low), 32'd64);

    // Reset in the middle of both sync pulses
    k = 0;
    while (!(x_sm == 10'd11 && y_sm == 10'd9) && k < 1000) begin step(); k++; end
    check("mid_hs_low", 32'(hs_sm), 32'd0);
    check("mid_vs_low", 32'(vs_sm), 32'd0);
    rst_sm = 1'b1;
    step();
    check("mid_rst_x",  32'(x_sm),  32'd0);
    check("mid_rst_y",  32'(y_sm),  32'd0);
    check("mid_rst_hs", 32'(hs_sm), 32'd1);
    check("mid_rst_vs", 32'(vs_sm), 32'd1);
    check("mid_rst_nb", 32'(nb_sm), 32'd1);
    check("mid_rst_fs", 32'(fs_sm), 32'd0);
    rst_sm = 1'b0;

    // Random reset pulses and run lengths, every cycle against the model
    for (int it = 0; it < 8; it++) begin
      k = int'($urandom_range(50, 2500));
      repeat (k) step();
      rst_def = $urandom_range(0, 1) == 1;
      rst_d4  = $urandom_range(0, 1) == 1;
      rst_sm  = $urandom_range(0, 1) == 1;
      k = int'($urandom_range(1, 3));
      repeat (k) step();
      rst_def = 1'b0; rst_d4 = 1'b0; rst_sm = 1'b0;
    end
    repeat (500) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
